// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for the PS/2 lines plus a run-length deglitcher on the clock.
module ps2_line_filter #(
    parameter int filter_len = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps_clock,
    input  logic ps_data,
    output logic fclk,
    output logic fall,
    output logic data
);

    localparam int CW = $clog2(filter_len + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [CW-1:0] run_cnt;

    assign data = dat_sync[1];

    // fclk only follows the synchronised clock once it has disagreed for filter_len samples in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            run_cnt  <= '0;
            fclk     <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps_clock};
            dat_sync <= {dat_sync[0], ps_data};
            fall     <= 1'b0;
            if (clk_sync[1] == fclk) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(filter_len - 1)) begin
                fclk    <= clk_sync[1];
                fall    <= ~clk_sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding into per-key flags.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int clk_mhz    = 50,
    parameter int timeout_us = 200,
    parameter int filter_len = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps_clock,
    input  logic       ps_data,
    output logic [7:0] code,
    output logic       extended,
    // break-code flag; "release" is a reserved word in SystemVerilog
    output logic       key_release,
    output logic       code_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int LIMIT = clk_mhz * timeout_us;
    localparam int TW    = $clog2(LIMIT + 1);

    logic          fclk;
    logic          fall;
    logic          data;
    state_t        state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          ext_pending;
    logic          brk_pending;
    logic          frame_good;

    ps2_line_filter #(.filter_len(filter_len)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps_clock (ps_clock),
        .ps_data  (ps_data),
        .fclk     (fclk),
        .fall     (fall),
        .data     (data)
    );

    // shreg fills LSB-first from the top: [7:0] data, [8] parity, [9] stop
    assign frame_good = (^shreg[8:0]) & shreg[9];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tcnt        <= '0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            code        <= '0;
            extended    <= 1'b0;
            key_release <= 1'b0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !data) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        shreg <= {data, shreg[9:1]};
                        tcnt  <= '0;
                        if (bit_cnt == 4'd9) state <= CHECK;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else if (tcnt == TW'(LIMIT)) begin
                        frame_error <= 1'b1;
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_good) begin
                        frame_error <= 1'b1;
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                    end else if (shreg[7:0] == PS2_EXT) begin
                        ext_pending <= 1'b1;
                    end else if (shreg[7:0] == PS2_BRK) begin
                        brk_pending <= 1'b1;
                    end else begin
                        code        <= shreg[7:0];
                        extended    <= ext_pending;
                        key_release <= brk_pending;
                        code_valid  <= 1'b1;
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Receives device-to-host PS/2 frames on the board's `ps_clock`/`ps_data` pins and decodes them into scan-code events. It sits directly upstream of `top`'s keyboard logic on the PS/2 path. It synchronises and deglitches the PS/2 clock, then shifts in 11-bit frames and checks start, parity and stop bits. It folds the `E0`/`F0` prefix bytes into per-key flags and emits one single-cycle event per key code.

## Interface
- `clk_mhz`, default 50: system clock frequency in MHz.
- `timeout_us`, default 200: maximum gap between PS/2 clock falling edges inside a frame, in µs.
- `filter_len`, default 8: number of consecutive equal synchronised samples required before the filtered PS/2 clock changes.

- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `ps_clock` input 1: raw PS/2 clock, asynchronous to `clk`. Idles high.
- `ps_data` input 1: raw PS/2 data, asynchronous to `clk`. The block never drives it; there is no host-to-device support.
- `code` output 8: last decoded key code, with prefixes removed.
- `extended` output 1: `code` was preceded by `E0`.
- `release` output 1: `code` was preceded by `F0` (break code).
- `code_valid` output 1: one-cycle pulse; `code`, `extended` and `release` are valid during it.
- `frame_error` output 1: one-cycle pulse on a parity error, stop-bit error or timeout.
- `busy` output 1: a frame is in progress (state is not IDLE).

## Operation
- **Synchronisation:** `ps_clock` and `ps_data` each pass through 2 flip-flops.
- **Deglitch:** the filtered clock `fclk` resets to 1. `fclk` takes the synchronised value only after `filter_len` consecutive equal samples.
- **Falling edge (`fall`):** a one-cycle strobe on the cycle `fclk` goes 1→0. Each `fall` samples the synchronised `ps_data`.
- **State machine** (states IDLE, SHIFT, CHECK):
  - IDLE: on `fall`, if data=0 (start bit), go to SHIFT with bit count 0. If data=1, stay in IDLE silently; this is noise and is not an error.
  - SHIFT: each `fall` stores a bit. Bits 0–7 go into the data byte LSB-first, bit 8 is parity, bit 9 is stop. After the stop bit, go to CHECK.
  - CHECK (one cycle): the frame is good iff the popcount of data+parity is odd and stop=1. Then return to IDLE.
  - Good frame: apply prefix decode. Bad frame: pulse `frame_error`, clear both pending flags, emit no event.
- **Timeout:** a counter is cleared on every `fall` and counts while the state is not IDLE. When it reaches `clk_mhz*timeout_us`, the frame is aborted: pulse `frame_error`, clear pending flags, go to IDLE. The counter width is `$clog2(clk_mhz*timeout_us+1)`.
- **Prefix decode** on a good byte:
  - `E0`: set `ext_pending`.
  - `F0`: set `brk_pending`.
  - Any other byte: load `code`, set `extended`=`ext_pending` and `release`=`brk_pending`, pulse `code_valid`, then clear both pending flags.
  - `code`, `extended` and `release` hold their values until the next event.
  - Bytes such as `AA`/`FA` are emitted like ordinary codes.
- **Reset:**
  - Outputs: `code`=0, `extended`=0, `release`=0, `code_valid`=0, `frame_error`=0, `busy`=0.
  - Internal: state IDLE, `fclk`=1, pending flags and counters cleared.
  - Reset mid-frame discards the partial frame. The next start bit begins cleanly.

## Timing
- Raw `ps_clock` fall → `fall` strobe: 2 + `filter_len` cycles.
- Stop-bit `fall` → CHECK on the next cycle → `code_valid`/`frame_error` registered on the cycle after CHECK.
- The timeout `frame_error` pulse occurs on the cycle after the counter reaches its limit.
- `code_valid` and `frame_error` are never asserted in the same cycle. Each is high for exactly 1 cycle.
- `busy` rises on the cycle after the start-bit `fall` and falls when IDLE is re-entered.

## Structure
- Package `ps2_pkg`:
  - state enum (IDLE, SHIFT, CHECK);
  - constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0.
- Sub-module `ps2_line_filter`: 2-FF synchroniser plus `filter_len` deglitcher. It outputs `fclk` and the `fall` strobe.
- The frame FSM, timeout counter and prefix decode live in the top module.

## Test plan
- **Single byte:** frame `1C`, odd-parity bit 0, stop 1, at a 12.5 kHz PS/2 clock → one `code_valid` with `code`=8'h1C, `extended`=0, `release`=0; no `frame_error`.
- **Prefixed sequence:** `E0`, `F0`, `75` → exactly one `code_valid`, with `code`=8'h75, `extended`=1, `release`=1. Then `1C` → `extended`=0, `release`=0.
- **Parity error:** `1C` sent with parity 1 → `frame_error` pulse and no `code_valid`. Preceding `F0` then `1C` with bad parity, then a good `1C` → `release`=0 (flag cleared by the error).
- **Stop error:** stop bit 0 → `frame_error`. Then a good `29` frame decodes to `code`=8'h29.
- **Timeout:** send start + 4 bits, then hold `ps_clock` high for 300 µs → `frame_error` 200 µs (10 000 cycles) after the last fall and `busy`=0. The next full `1C` decodes correctly.
- **Glitch and reset:**
  - A 3-cycle low pulse on `ps_clock` while idle → no `fall`, `busy` stays 0.
  - Assert `rst` after bit 5 of a frame → all outputs 0. The next full `1C` frame decodes correctly.
